// File: rtl/demux_1_to_16_buf.sv
// rtl/demux_1_to_16_buf.sv - registered 1-to-16 demultiplexer with per-channel holding registers
//
// Purpose:
//   Accepts one word per cycle on a valid/ready input and steers it to one of
//   16 single-entry output channels (or to all 16 at once on broadcast).
//   Every channel has its own valid/ready handshake toward its consumer.
//
// Ports:
//   clock      in   1        system clock, rising edge
//   reset      in   1        synchronous active-high reset
//   in_data    in   bits     input word
//   in_sel     in   4        destination channel, ignored when in_bcast=1
//   in_bcast   in   1        write in_data to all 16 channels
//   in_valid   in   1        input word present
//   in_ready   out  1        input word accepted when in_valid & in_ready
//   out_data   out  16*bits  channel k data at [k*bits +: bits]
//   out_valid  out  16       per-channel holding register full
//   out_ready  in   16       per-channel consumer ready
//   occupancy  out  5        number of full channels, 0..16
module demux_1_to_16_buf #(
    parameter int bits = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [bits-1:0]    in_data,
    input  logic [3:0]         in_sel,
    input  logic               in_bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [16*bits-1:0] out_data,
    output logic [15:0]        out_valid,
    input  logic [15:0]        out_ready,
    output logic [4:0]         occupancy
);

    logic [15:0] free;
    logic [15:0] load;
    logic [15:0] next_valid;
    logic [4:0]  next_count;
    logic        accept;

    // A channel can take a word if it is empty or is being drained this cycle,
    // which gives same-cycle drain-and-refill at full throughput.
    always_comb begin
        free = ~out_valid | out_ready;
    end

    // Broadcast waits until every channel can take the word so no channel is
    // ever overwritten while still holding undelivered data.
    assign in_ready = !reset && (in_bcast ? (&free) : free[in_sel]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        load       = '0;
        next_valid = '0;
        next_count = '0;
        for (int k = 0; k < 16; k++) begin
            load[k]       = accept && (in_bcast || (in_sel == 4'(k)));
            next_valid[k] = load[k] || (out_valid[k] && !out_ready[k]);
            next_count    = next_count + {4'd0, next_valid[k]};
        end
    end

    // Occupancy is registered from the next-state vector so it always matches
    // popcount(out_valid) without a combinational adder tree on the output.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            occupancy <= '0;
        end else begin
            out_valid <= next_valid;
            occupancy <= next_count;
            for (int k = 0; k < 16; k++) begin
                if (load[k]) begin
                    out_data[k*bits +: bits] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1_to_16_buf.sv
// tb/tb_demux_1_to_16_buf.sv - scoreboard testbench for demux_1_to_16_buf
module tb_demux_1_to_16_buf;

    localparam int BITS = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic [BITS-1:0]    in_data;
    logic [3:0]         in_sel;
    logic               in_bcast;
    logic               in_valid;
    logic               in_ready;
    logic [16*BITS-1:0] out_data;
    logic [15:0]        out_valid;
    logic [15:0]        out_ready;
    logic [4:0]         occupancy;

    int checks = 0;
    int errors = 0;

    // Expected contents of each channel (at most one entry) and the value each
    // channel shows once drained.
    logic [BITS-1:0] q [16][$];
    logic [BITS-1:0] hold [16];

    demux_1_to_16_buf #(.bits(BITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT state to the scoreboard every cycle and pops on drain.
    always @(negedge clock) begin
        logic [15:0]        exp_v;
        logic [16*BITS-1:0] exp_d;
        logic [15:0]        exp_free;
        logic               exp_rdy;
        exp_v = '0;
        exp_d = '0;
        for (int k = 0; k < 16; k++) begin
            if (q[k].size() > 0) begin
                exp_v[k] = 1'b1;
                exp_d[k*BITS +: BITS] = q[k][0];
            end else begin
                exp_d[k*BITS +: BITS] = hold[k];
            end
        end
        chk("out_valid", 128'(out_valid), 128'(exp_v));
        chk("out_data", 128'(out_data), 128'(exp_d));
        chk("occupancy", 128'(occupancy), 128'($countones(exp_v)));
        if (reset) begin
            chk("in_ready_reset", 128'(in_ready), 128'(0));
            for (int k = 0; k < 16; k++) begin
                q[k].delete();
                hold[k] = '0;
            end
        end else begin
            exp_free = ~exp_v | out_ready;
            exp_rdy  = in_bcast ? (&exp_free) : exp_free[in_sel];
            chk("in_ready", 128'(in_ready), 128'(exp_rdy));
            for (int k = 0; k < 16; k++) begin
                if (exp_v[k] && out_ready[k]) begin
                    hold[k] = q[k].pop_front();
                end
            end
        end
    end

    // Driver: applies one cycle of stimulus and records accepted words.
    task automatic cyc(input logic rst, input logic v, input logic [3:0] s, input logic b,
                       input logic [BITS-1:0] d, input logic [15:0] rdy);
        @(posedge clock);
        #1;
        reset     = rst;
        in_valid  = v;
        in_sel    = s;
        in_bcast  = b;
        in_data   = d;
        out_ready = rdy;
        @(negedge clock);
        #1;
        if (in_valid && in_ready) begin
            for (int k = 0; k < 16; k++) begin
                if (in_bcast || (in_sel == 4'(k))) q[k].push_back(in_data);
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0;
        in_data = '0; out_ready = '0;
        for (int k = 0; k < 16; k++) hold[k] = '0;

        cyc(1'b1, 1'b1, 4'd2, 1'b0, 8'h55, 16'h0000);
        cyc(1'b1, 1'b1, 4'd2, 1'b0, 8'h55, 16'h0000);

        // 1: single unicast write
        cyc(1'b0, 1'b1, 4'd5, 1'b0, 8'hA5, 16'h0000);
        chk("t1_in_ready", 128'(in_ready), 128'(1));
        idle();
        chk("t1_out_valid", 128'(out_valid), 128'(16'h0020));
        chk("t1_out_data", 128'(out_data[47:40]), 128'(8'hA5));
        chk("t1_occupancy", 128'(occupancy), 128'(1));
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 16'h0020);
        idle();
        chk("t1_drained", 128'(occupancy), 128'(0));

        // 2: blocked channel, then drain-and-refill
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 8'h11, 16'h0000);
        idle();
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 8'h22, 16'h0000);
        chk("t2_blocked", 128'(in_ready), 128'(0));
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 8'h3C, 16'h0008);
        chk("t2_refill_rdy", 128'(in_ready), 128'(1));
        idle();
        chk("t2_out_valid", 128'(out_valid), 128'(16'h0008));
        chk("t2_out_data", 128'(out_data[31:24]), 128'(8'h3C));
        chk("t2_occupancy", 128'(occupancy), 128'(1));
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 16'h0008);
        idle();

        // 3: fill all channels, everything blocks, drain one
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0, 8'(i), 16'h0000);
        idle();
        chk("t3_full", 128'(occupancy), 128'(16));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'(i), 1'b0, 8'hFF, 16'h0000);
            chk("t3_in_ready", 128'(in_ready), 128'(0));
        end
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 16'h8000);
        idle();
        chk("t3_occ15", 128'(occupancy), 128'(15));

        // 4: broadcast blocked by channel 9, then released
        cyc(1'b0, 1'b1, 4'd0, 1'b1, 8'h77, 16'hFDFF);
        chk("t4_blocked", 128'(in_ready), 128'(0));
        cyc(1'b0, 1'b1, 4'd0, 1'b1, 8'h77, 16'hFFFF);
        chk("t4_release", 128'(in_ready), 128'(1));
        idle();
        chk("t4_out_valid", 128'(out_valid), 128'(16'hFFFF));
        chk("t4_occupancy", 128'(occupancy), 128'(16));
        chk("t4_out_data", 128'(out_data), {16{8'h77}});

        // 5: reset with 7 channels full and a handshake offered
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0, 8'h40 + 8'(i), 16'h0000);
        idle();
        chk("t5_occ7", 128'(occupancy), 128'(7));
        cyc(1'b1, 1'b1, 4'd7, 1'b0, 8'h99, 16'h0001);
        chk("t5_in_ready", 128'(in_ready), 128'(0));
        idle();
        chk("t5_out_valid", 128'(out_valid), 128'(0));
        chk("t5_out_data", 128'(out_data), 128'(0));
        chk("t5_occupancy", 128'(occupancy), 128'(0));

        // 6: random traffic checked by the monitor
        for (int i = 0; i < 10000; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 15) == 0), 8'($urandom), 16'($urandom));
        end
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
        idle();
        chk("t6_empty", 128'(occupancy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
